// File: rtl/signal_conflict_monitor.sv
// signal_conflict_monitor: safety stage between the light sequencer and the lamps.
// Decodes 2-bit light codes to one-hot {R,Y,G} lamps. It checks every sample for
// illegal codes, conflicting greens, illegal transitions, short yellows and a stuck
// sequencer. On any violation the lamps flash red until fault_clear is asserted.
module signal_conflict_monitor #(
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ns_light,
  input  logic [1:0] ew_light,
  input  logic       fault_clear,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       running
);

  localparam int unsigned YcW = $clog2(MIN_YELLOW + 1);
  localparam int unsigned HcW = $clog2(MAX_HOLD + 1);
  localparam int unsigned FcW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [1:0] LtRed    = 2'b00;
  localparam logic [1:0] LtYellow = 2'b01;
  localparam logic [1:0] LtGreen  = 2'b10;
  localparam logic [1:0] LtBad    = 2'b11;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampOff = 3'b000;

  typedef enum logic [1:0] {StStart, StRun, StFault} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ns_q, ns_d, ew_q, ew_d;
  logic [YcW-1:0]   yc_ns_q, yc_ns_d, yc_ew_q, yc_ew_d;
  logic [HcW-1:0]   hc_q, hc_d;
  logic [FcW-1:0]   flash_cnt_q, flash_cnt_d;
  logic             flash_on_q, flash_on_d;
  logic [2:0]       ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
  logic             fault_q, fault_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic             running_q, running_d;

  logic [2:0]       viol_code;
  logic             same_pair;

  function automatic logic [2:0] decode(input logic [1:0] code);
    unique case (code)
      LtRed:    decode = 3'b100;
      LtYellow: decode = 3'b010;
      LtGreen:  decode = 3'b001;
      default:  decode = 3'b000;
    endcase
  endfunction

  function automatic logic trans_ok(input logic [1:0] prev, input logic [1:0] cur);
    trans_ok = (cur == prev) ||
               (prev == LtRed    && cur == LtGreen) ||
               (prev == LtGreen  && cur == LtYellow) ||
               (prev == LtYellow && cur == LtRed);
  endfunction

  assign same_pair = (ns_light == ns_q) && (ew_light == ew_q);

  // Violation classifier; the else-if chain makes the lowest code win.
  always_comb begin
    viol_code = 3'd0;
    if (ns_light == LtBad || ew_light == LtBad) begin
      viol_code = 3'd1;
    end else if (ns_light != LtRed && ew_light != LtRed) begin
      viol_code = 3'd2;
    end else if (state_q == StRun) begin
      if (!trans_ok(ns_q, ns_light) || !trans_ok(ew_q, ew_light)) begin
        viol_code = 3'd3;
      end else if ((ns_q == LtYellow && ns_light == LtRed && yc_ns_q < YcW'(MIN_YELLOW)) ||
                   (ew_q == LtYellow && ew_light == LtRed && yc_ew_q < YcW'(MIN_YELLOW))) begin
        viol_code = 3'd4;
      end else if (same_pair && hc_q == HcW'(MAX_HOLD)) begin
        viol_code = 3'd5;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ns_d         = ns_q;
    ew_d         = ew_q;
    yc_ns_d      = yc_ns_q;
    yc_ew_d      = yc_ew_q;
    hc_d         = hc_q;
    flash_cnt_d  = flash_cnt_q;
    flash_on_d   = flash_on_q;
    ns_lamp_d    = ns_lamp_q;
    ew_lamp_d    = ew_lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    running_d    = running_q;

    unique case (state_q)
      StStart, StRun: begin
        if (viol_code != 3'd0) begin
          // Offending sample never reaches the lamps.
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_code_d = viol_code;
          ns_lamp_d    = LampRed;
          ew_lamp_d    = LampRed;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b1;
          running_d    = 1'b0;
        end else begin
          state_d   = StRun;
          running_d = 1'b1;
          ns_lamp_d = decode(ns_light);
          ew_lamp_d = decode(ew_light);
          ns_d      = ns_light;
          ew_d      = ew_light;
          // No previous sample exists in START, so the hold run starts at 1.
          if (state_q == StRun && same_pair) begin
            hc_d = (hc_q < HcW'(MAX_HOLD)) ? hc_q + HcW'(1) : hc_q;
          end else begin
            hc_d = HcW'(1);
          end
          if (ns_light == LtYellow) begin
            yc_ns_d = (state_q == StRun && yc_ns_q < YcW'(MIN_YELLOW)) ? yc_ns_q + YcW'(1) :
                      (state_q == StRun) ? yc_ns_q : YcW'(1);
          end else begin
            yc_ns_d = '0;
          end
          if (ew_light == LtYellow) begin
            yc_ew_d = (state_q == StRun && yc_ew_q < YcW'(MIN_YELLOW)) ? yc_ew_q + YcW'(1) :
                      (state_q == StRun) ? yc_ew_q : YcW'(1);
          end else begin
            yc_ew_d = '0;
          end
        end
      end
      StFault: begin
        if (fault_clear) begin
          state_d      = StStart;
          fault_d      = 1'b0;
          fault_code_d = 3'd0;
          ns_lamp_d    = LampRed;
          ew_lamp_d    = LampRed;
          flash_cnt_d  = '0;
          flash_on_d   = 1'b0;
          hc_d         = '0;
          yc_ns_d      = '0;
          yc_ew_d      = '0;
        end else begin
          if (flash_cnt_q == FcW'(FLASH_HALF - 1)) begin
            flash_cnt_d = '0;
            flash_on_d  = ~flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + FcW'(1);
          end
          ns_lamp_d = flash_on_d ? LampRed : LampOff;
          ew_lamp_d = flash_on_d ? LampRed : LampOff;
        end
      end
      default: begin
        state_d = StStart;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StStart;
      ns_q         <= LtRed;
      ew_q         <= LtRed;
      yc_ns_q      <= '0;
      yc_ew_q      <= '0;
      hc_q         <= '0;
      flash_cnt_q  <= '0;
      flash_on_q   <= 1'b0;
      ns_lamp_q    <= LampRed;
      ew_lamp_q    <= LampRed;
      fault_q      <= 1'b0;
      fault_code_q <= 3'd0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ns_q         <= ns_d;
      ew_q         <= ew_d;
      yc_ns_q      <= yc_ns_d;
      yc_ew_q      <= yc_ew_d;
      hc_q         <= hc_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_on_q   <= flash_on_d;
      ns_lamp_q    <= ns_lamp_d;
      ew_lamp_q    <= ew_lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      running_q    <= running_d;
    end
  end

  assign ns_lamp    = ns_lamp_q;
  assign ew_lamp    = ew_lamp_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign running    = running_q;

endmodule
